// File: rtl/coin_start_sequencer.sv
// Frame-timed coin/start sequencer: turns a 1P/2P start request into N coin
// pulses, a settle gap and a start pulse on the core's input switches.
module coin_start_sequencer #(
    parameter int unsigned COIN_FRAMES  = 3,
    parameter int unsigned GAP_FRAMES   = 4,
    parameter int unsigned START_FRAMES = 3
) (
    input  logic CLK,
    input  logic RESET,
    input  logic ENA_6,
    input  logic I_VBLANK,
    input  logic I_START1,
    input  logic I_START2,
    input  logic I_COIN,
    output logic O_COIN,
    output logic O_START1,
    output logic O_START2,
    output logic O_BUSY
);

    typedef enum logic [2:0] {
        IDLE,
        COIN_ON,
        COIN_GAP,
        START_ON,
        RELEASE
    } state_t;

    localparam logic [7:0] COIN_LD  = 8'(COIN_FRAMES);
    localparam logic [7:0] GAP_LD   = 8'(GAP_FRAMES);
    localparam logic [7:0] START_LD = 8'(START_FRAMES);

    state_t     state;
    logic [7:0] frame_cnt;
    logic [1:0] coins_left;
    logic [1:0] player;
    logic       vb_q;
    logic       s1_q;
    logic       s2_q;

    logic frame_tick;
    logic s1_rise;
    logic s2_rise;
    logic last_tick;

    assign frame_tick = I_VBLANK & ~vb_q;
    assign s1_rise    = I_START1 & ~s1_q;
    assign s2_rise    = I_START2 & ~s2_q;
    // A state ends on the tick that would take the counter from 1 to 0.
    assign last_tick  = frame_tick && (frame_cnt == 8'd1);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= IDLE;
            frame_cnt  <= '0;
            coins_left <= '0;
            player     <= '0;
            vb_q       <= 1'b0;
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            O_COIN     <= 1'b0;
            O_START1   <= 1'b0;
            O_START2   <= 1'b0;
            O_BUSY     <= 1'b0;
        end else if (ENA_6) begin
            vb_q <= I_VBLANK;
            s1_q <= I_START1;
            s2_q <= I_START2;

            unique case (state)
                IDLE: begin
                    O_COIN <= I_COIN;
                    if (s2_rise) begin
                        player     <= 2'd2;
                        coins_left <= 2'd2;
                        frame_cnt  <= COIN_LD;
                        state      <= COIN_ON;
                        O_COIN     <= 1'b1;
                        O_BUSY     <= 1'b1;
                    end else if (s1_rise) begin
                        player     <= 2'd1;
                        coins_left <= 2'd1;
                        frame_cnt  <= COIN_LD;
                        state      <= COIN_ON;
                        O_COIN     <= 1'b1;
                        O_BUSY     <= 1'b1;
                    end
                end

                COIN_ON: begin
                    if (last_tick) begin
                        coins_left <= coins_left - 2'd1;
                        frame_cnt  <= GAP_LD;
                        state      <= COIN_GAP;
                        O_COIN     <= 1'b0;
                    end else if (frame_tick) begin
                        frame_cnt <= frame_cnt - 8'd1;
                    end
                end

                COIN_GAP: begin
                    if (last_tick) begin
                        if (coins_left != 2'd0) begin
                            frame_cnt <= COIN_LD;
                            state     <= COIN_ON;
                            O_COIN    <= 1'b1;
                        end else begin
                            frame_cnt <= START_LD;
                            state     <= START_ON;
                            O_START1  <= (player == 2'd1);
                            O_START2  <= (player == 2'd2);
                        end
                    end else if (frame_tick) begin
                        frame_cnt <= frame_cnt - 8'd1;
                    end
                end

                START_ON: begin
                    if (last_tick) begin
                        state    <= RELEASE;
                        O_START1 <= 1'b0;
                        O_START2 <= 1'b0;
                    end else if (frame_tick) begin
                        frame_cnt <= frame_cnt - 8'd1;
                    end
                end

                RELEASE: begin
                    // Wait for every start key to be let go so a held key cannot re-trigger.
                    if (!I_START1 && !I_START2) begin
                        state  <= IDLE;
                        O_BUSY <= 1'b0;
                    end
                end

                default: begin
                    state    <= IDLE;
                    O_COIN   <= 1'b0;
                    O_START1 <= 1'b0;
                    O_START2 <= 1'b0;
                    O_BUSY   <= 1'b0;
                end
            endcase
        end
    end

endmodule
